// File: rtl/freelist_ctrl_pkg.sv
// freelist_ctrl_pkg: shared tag width, default sizes and freelist controller state encoding
package freelist_ctrl_pkg;
    localparam int PHYS_TAG = 6;
    localparam int N_WAY    = 3;
    localparam int ROB_SZ   = 16;

    typedef enum logic [1:0] {
        NORMAL,
        RECOVER,
        SETTLE
    } fl_ctrl_state_e;
endpackage

// File: rtl/freelist_ctrl_lane_compact.sv
// lane_compact: packs valid lanes toward lane 0 in lane order and reports how many were packed
module lane_compact #(
    parameter int N  = 3,
    parameter int W  = 6,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         valid,
    input  logic [N-1:0][W-1:0]  din,
    output logic [N-1:0][W-1:0]  dout,
    output logic [CW-1:0]        count
);
    // each valid lane lands at the slot equal to the number of valid lanes below it
    always_comb begin
        dout  = '0;
        count = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                dout[count] = din[i];
                count       = count + CW'(1);
            end
        end
    end
endmodule

// File: rtl/freelist_ctrl.sv
// freelist_ctrl: dispatch allocation, return-port arbitration and squash recovery sequencing
module freelist_ctrl
    import freelist_ctrl_pkg::*;
#(
    parameter int N      = N_WAY,
    parameter int SQ_MAX = ROB_SZ,
    parameter int SQW    = $clog2(SQ_MAX + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N-1:0]                disp_valid,
    input  logic [N-1:0]                disp_has_dest,
    output logic [N-1:0]                disp_grant,
    output logic [N-1:0][PHYS_TAG-1:0]  disp_tag,
    input  logic [N-1:0]                commit_free_valid,
    input  logic [N-1:0][PHYS_TAG-1:0]  commit_free_tag,
    input  logic                        squash_start,
    input  logic [SQW-1:0]              squash_count,
    input  logic [N-1:0]                sq_valid,
    input  logic [N-1:0][PHYS_TAG-1:0]  sq_tag,
    output logic                        sq_ready,
    output logic [N-1:0]                fl_dispatch_en,
    input  logic [N-1:0][PHYS_TAG-1:0]  fl_free_reg,
    input  logic [N-1:0]                fl_free_valid,
    output logic [N-1:0]                fl_retire_en,
    output logic [N-1:0][PHYS_TAG-1:0]  fl_retire_reg,
    output logic                        recovering,
    output logic [SQW-1:0]              sq_freed
);
    localparam int CW = $clog2(N + 1);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    fl_ctrl_state_e             state;
    logic [SQW-1:0]             expected;
    logic [N-1:0][LW-1:0]       lane_idx;
    logic [N-1:0][LW-1:0]       dest_map;
    logic [CW-1:0]              dest_cnt;
    logic [N-1:0][PHYS_TAG-1:0] commit_pack;
    logic [CW-1:0]              commit_cnt;
    logic                       dispatch_ok;
    logic                       run;
    int                         rank;
    int                         m_cnt;
    int                         s_cnt;

    for (genvar i = 0; i < N; i++) begin : g_idx
        assign lane_idx[i] = LW'(i);
    end

    lane_compact #(.N(N), .W(LW)) u_dest (
        .valid (disp_valid & disp_has_dest),
        .din   (lane_idx),
        .dout  (dest_map),
        .count (dest_cnt)
    );

    lane_compact #(.N(N), .W(PHYS_TAG)) u_commit (
        .valid (commit_free_valid),
        .din   (commit_free_tag),
        .dout  (commit_pack),
        .count (commit_cnt)
    );

    // in-order grant: a lane goes only if all older lanes went and a tag is left for it
    always_comb begin
        dispatch_ok    = !reset && state == NORMAL && !squash_start;
        m_cnt          = $countones(fl_free_valid);
        disp_grant     = '0;
        disp_tag       = '0;
        fl_dispatch_en = '0;
        run            = dispatch_ok;
        rank           = 0;
        for (int i = 0; i < N; i++) begin
            if (run && disp_valid[i] && (!disp_has_dest[i] || rank < m_cnt)) disp_grant[i] = 1'b1;
            else run = 1'b0;
            if (disp_valid[i] && disp_has_dest[i]) rank++;
        end
        for (int k = 0; k < N; k++) begin
            if (dispatch_ok && k < int'(dest_cnt)) begin
                fl_dispatch_en[k]     = 1'b1;
                disp_tag[dest_map[k]] = fl_free_reg[k];
            end
        end
    end

    // commit frees take the low retire lanes; the squash walk fills the rest all-or-nothing
    always_comb begin
        s_cnt         = $countones(sq_valid);
        sq_ready      = !reset && state == RECOVER && s_cnt > 0 &&
                        int'(commit_cnt) + s_cnt <= N &&
                        int'(sq_freed) + s_cnt <= int'(expected);
        fl_retire_en  = '0;
        fl_retire_reg = '0;
        for (int k = 0; k < N; k++) begin
            if (!reset && k < int'(commit_cnt)) begin
                fl_retire_en[k]  = 1'b1;
                fl_retire_reg[k] = commit_pack[k];
            end
        end
        for (int j = 0; j < N; j++) begin
            if (sq_ready && j < s_cnt) begin
                fl_retire_en[int'(commit_cnt) + j]  = 1'b1;
                fl_retire_reg[int'(commit_cnt) + j] = sq_tag[j];
            end
        end
    end

    // recovery sequencer: latch the squash size, count returned tags, settle one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= NORMAL;
            sq_freed   <= '0;
            expected   <= '0;
            recovering <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (squash_start) begin
                        expected   <= squash_count;
                        sq_freed   <= '0;
                        state      <= (squash_count != '0) ? RECOVER : SETTLE;
                        recovering <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (sq_ready) begin
                        sq_freed <= sq_freed + SQW'(s_cnt);
                        if (int'(sq_freed) + s_cnt == int'(expected)) state <= SETTLE;
                    end
                end
                SETTLE: begin
                    state      <= NORMAL;
                    recovering <= 1'b0;
                end
                default: begin
                    state      <= NORMAL;
                    recovering <= 1'b0;
                end
            endcase
        end
    end

    // a second mispredict must not arrive while a walk is in progress
    a_no_restart: assert property (@(posedge clock) disable iff (reset)
        !(state == RECOVER && squash_start));
endmodule

// File: tb/tb_freelist_ctrl.sv
// tb_freelist_ctrl: scoreboard-driven checks of dispatch, return arbitration and squash recovery
module tb_freelist_ctrl;
    logic             clock;
    logic             reset;
    logic [2:0]       disp_valid, disp_has_dest, disp_grant;
    logic [2:0][5:0]  disp_tag;
    logic [2:0]       commit_free_valid;
    logic [2:0][5:0]  commit_free_tag;
    logic             squash_start;
    logic [4:0]       squash_count;
    logic [2:0]       sq_valid;
    logic [2:0][5:0]  sq_tag;
    logic             sq_ready;
    logic [2:0]       fl_dispatch_en;
    logic [2:0][5:0]  fl_free_reg;
    logic [2:0]       fl_free_valid;
    logic [2:0]       fl_retire_en;
    logic [2:0][5:0]  fl_retire_reg;
    logic             recovering;
    logic [4:0]       sq_freed;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0]      grant;
        logic [2:0]      den;
        logic [2:0]      tmask;
        logic [2:0][5:0] tag;
        logic [2:0]      ren;
        logic [2:0][5:0] rreg;
        logic            rdy;
        logic            rec;
        logic [4:0]      freed;
    } exp_t;

    exp_t sb[$];

    freelist_ctrl #(.N(3), .SQ_MAX(16), .SQW(5)) dut (
        .clock             (clock),
        .reset             (reset),
        .disp_valid        (disp_valid),
        .disp_has_dest     (disp_has_dest),
        .disp_grant        (disp_grant),
        .disp_tag          (disp_tag),
        .commit_free_valid (commit_free_valid),
        .commit_free_tag   (commit_free_tag),
        .squash_start      (squash_start),
        .squash_count      (squash_count),
        .sq_valid          (sq_valid),
        .sq_tag            (sq_tag),
        .sq_ready          (sq_ready),
        .fl_dispatch_en    (fl_dispatch_en),
        .fl_free_reg       (fl_free_reg),
        .fl_free_valid     (fl_free_valid),
        .fl_retire_en      (fl_retire_en),
        .fl_retire_reg     (fl_retire_reg),
        .recovering        (recovering),
        .sq_freed          (sq_freed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t ex(logic [2:0] grant, logic [2:0] den, logic [2:0] tmask,
                                logic [2:0][5:0] tag, logic [2:0] ren, logic [2:0][5:0] rreg,
                                logic rdy, logic rec, logic [4:0] freed);
        exp_t e;
        e.grant = grant; e.den = den; e.tmask = tmask; e.tag = tag;
        e.ren = ren; e.rreg = rreg; e.rdy = rdy; e.rec = rec; e.freed = freed;
        return e;
    endfunction

    task automatic idle();
        disp_valid = '0; disp_has_dest = '0; fl_free_valid = '0; fl_free_reg = '0;
        commit_free_valid = '0; commit_free_tag = '0;
        squash_start = 1'b0; squash_count = '0; sq_valid = '0; sq_tag = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int t = 0; t < 2; t++) begin
            @(negedge clock);
            idle();
            case (t)
                0: begin
                    reset = 1'b1; disp_valid = 3'b111; fl_free_valid = 3'b111;
                    commit_free_valid = 3'b111; commit_free_tag = {6'd3, 6'd2, 6'd1};
                    sq_valid = 3'b111;
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
                default: begin
                    reset = 1'b0; disp_valid = 3'b001;
                    sb.push_back(ex(3'b001, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
            endcase
            #2;
            e = sb.pop_front();
            n_tests++; if (disp_grant !== e.grant) begin n_fail++; $display("FAIL reset[%0d] grant got %b want %b", t, disp_grant, e.grant); end
            n_tests++; if (fl_dispatch_en !== e.den) begin n_fail++; $display("FAIL reset[%0d] dispatch_en got %b want %b", t, fl_dispatch_en, e.den); end
            n_tests++; if (fl_retire_en !== e.ren) begin n_fail++; $display("FAIL reset[%0d] retire_en got %b want %b", t, fl_retire_en, e.ren); end
            n_tests++; if (fl_retire_reg !== e.rreg) begin n_fail++; $display("FAIL reset[%0d] retire_reg got %h want %h", t, fl_retire_reg, e.rreg); end
            n_tests++; if (sq_ready !== e.rdy) begin n_fail++; $display("FAIL reset[%0d] sq_ready got %b want %b", t, sq_ready, e.rdy); end
            n_tests++; if (recovering !== e.rec) begin n_fail++; $display("FAIL reset[%0d] recovering got %b want %b", t, recovering, e.rec); end
            n_tests++; if (sq_freed !== e.freed) begin n_fail++; $display("FAIL reset[%0d] sq_freed got %0d want %0d", t, sq_freed, e.freed); end
        end
    endtask

    task automatic test_dispatch();
        exp_t e;
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            idle();
            case (t)
                0: begin
                    disp_valid = 3'b111; disp_has_dest = 3'b101;
                    fl_free_valid = 3'b011; fl_free_reg = {6'd0, 6'd41, 6'd40};
                    sb.push_back(ex(3'b111, 3'b011, 3'b101, {6'd41, 6'd0, 6'd40}, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
                1: begin
                    disp_valid = 3'b011; disp_has_dest = 3'b111;
                    fl_free_valid = 3'b001; fl_free_reg = {6'd0, 6'd0, 6'd50};
                    sb.push_back(ex(3'b001, 3'b011, 3'b001, {6'd0, 6'd0, 6'd50}, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
                2: begin
                    disp_valid = 3'b111; disp_has_dest = 3'b010;
                    sb.push_back(ex(3'b001, 3'b001, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
                3: begin
                    disp_valid = 3'b111; disp_has_dest = 3'b111;
                    fl_free_valid = 3'b111; fl_free_reg = {6'd12, 6'd11, 6'd10};
                    commit_free_valid = 3'b110; commit_free_tag = {6'd9, 6'd7, 6'd0};
                    sq_valid = 3'b001; sq_tag = {6'd0, 6'd0, 6'd5};
                    sb.push_back(ex(3'b111, 3'b111, 3'b111, {6'd12, 6'd11, 6'd10}, 3'b011, {6'd0, 6'd9, 6'd7}, 1'b0, 1'b0, 5'd0));
                end
                default: begin
                    fl_free_valid = 3'b111;
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
            endcase
            #2;
            e = sb.pop_front();
            n_tests++; if (disp_grant !== e.grant) begin n_fail++; $display("FAIL dispatch[%0d] grant got %b want %b", t, disp_grant, e.grant); end
            n_tests++; if (fl_dispatch_en !== e.den) begin n_fail++; $display("FAIL dispatch[%0d] dispatch_en got %b want %b", t, fl_dispatch_en, e.den); end
            for (int i = 0; i < 3; i++) if (e.tmask[i]) begin
                n_tests++; if (disp_tag[i] !== e.tag[i]) begin n_fail++; $display("FAIL dispatch[%0d] tag%0d got %0d want %0d", t, i, disp_tag[i], e.tag[i]); end
            end
            n_tests++; if (fl_retire_en !== e.ren) begin n_fail++; $display("FAIL dispatch[%0d] retire_en got %b want %b", t, fl_retire_en, e.ren); end
            n_tests++; if (fl_retire_reg !== e.rreg) begin n_fail++; $display("FAIL dispatch[%0d] retire_reg got %h want %h", t, fl_retire_reg, e.rreg); end
            n_tests++; if (sq_ready !== e.rdy) begin n_fail++; $display("FAIL dispatch[%0d] sq_ready got %b want %b", t, sq_ready, e.rdy); end
        end
    endtask

    task automatic test_squash_walk();
        exp_t e;
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            idle();
            disp_valid = 3'b001;
            case (t)
                0: begin
                    squash_start = 1'b1; squash_count = 5'd5;
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
                1: begin
                    sq_valid = 3'b111; sq_tag = {6'd22, 6'd21, 6'd20};
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b111, {6'd22, 6'd21, 6'd20}, 1'b1, 1'b1, 5'd0));
                end
                2: begin
                    sq_valid = 3'b011; sq_tag = {6'd0, 6'd24, 6'd23};
                    commit_free_valid = 3'b001; commit_free_tag = {6'd0, 6'd0, 6'd30};
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b111, {6'd24, 6'd23, 6'd30}, 1'b1, 1'b1, 5'd3));
                end
                3: begin
                    sq_valid = 3'b011; sq_tag = {6'd0, 6'd26, 6'd25};
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b1, 5'd5));
                end
                default: begin
                    sb.push_back(ex(3'b001, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd5));
                end
            endcase
            #2;
            e = sb.pop_front();
            n_tests++; if (disp_grant !== e.grant) begin n_fail++; $display("FAIL walk[%0d] grant got %b want %b", t, disp_grant, e.grant); end
            n_tests++; if (fl_retire_en !== e.ren) begin n_fail++; $display("FAIL walk[%0d] retire_en got %b want %b", t, fl_retire_en, e.ren); end
            n_tests++; if (fl_retire_reg !== e.rreg) begin n_fail++; $display("FAIL walk[%0d] retire_reg got %h want %h", t, fl_retire_reg, e.rreg); end
            n_tests++; if (sq_ready !== e.rdy) begin n_fail++; $display("FAIL walk[%0d] sq_ready got %b want %b", t, sq_ready, e.rdy); end
            n_tests++; if (recovering !== e.rec) begin n_fail++; $display("FAIL walk[%0d] recovering got %b want %b", t, recovering, e.rec); end
            n_tests++; if (sq_freed !== e.freed) begin n_fail++; $display("FAIL walk[%0d] sq_freed got %0d want %0d", t, sq_freed, e.freed); end
        end
    endtask

    task automatic test_squash_zero();
        exp_t e;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            idle();
            disp_valid = 3'b001;
            case (t)
                0: begin
                    squash_start = 1'b1; squash_count = 5'd0;
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd5));
                end
                1: begin
                    sq_valid = 3'b001; sq_tag = {6'd0, 6'd0, 6'd1};
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b1, 5'd0));
                end
                default: begin
                    sb.push_back(ex(3'b001, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
            endcase
            #2;
            e = sb.pop_front();
            n_tests++; if (disp_grant !== e.grant) begin n_fail++; $display("FAIL zero[%0d] grant got %b want %b", t, disp_grant, e.grant); end
            n_tests++; if (fl_retire_en !== e.ren) begin n_fail++; $display("FAIL zero[%0d] retire_en got %b want %b", t, fl_retire_en, e.ren); end
            n_tests++; if (sq_ready !== e.rdy) begin n_fail++; $display("FAIL zero[%0d] sq_ready got %b want %b", t, sq_ready, e.rdy); end
            n_tests++; if (recovering !== e.rec) begin n_fail++; $display("FAIL zero[%0d] recovering got %b want %b", t, recovering, e.rec); end
            n_tests++; if (sq_freed !== e.freed) begin n_fail++; $display("FAIL zero[%0d] sq_freed got %0d want %0d", t, sq_freed, e.freed); end
        end
    endtask

    task automatic test_reset_mid_recover();
        exp_t e;
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            idle();
            case (t)
                0: begin
                    squash_start = 1'b1; squash_count = 5'd4;
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
                1: begin
                    commit_free_valid = 3'b101; commit_free_tag = {6'd35, 6'd0, 6'd33};
                    sq_valid = 3'b011; sq_tag = {6'd0, 6'd61, 6'd60};
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b011, {6'd0, 6'd35, 6'd33}, 1'b0, 1'b1, 5'd0));
                end
                2: begin
                    sq_valid = 3'b011; sq_tag = {6'd0, 6'd61, 6'd60};
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b011, {6'd0, 6'd61, 6'd60}, 1'b1, 1'b1, 5'd0));
                end
                3: begin
                    sq_valid = 3'b111; sq_tag = {6'd52, 6'd51, 6'd50};
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b1, 5'd2));
                end
                4: begin
                    reset = 1'b1; disp_valid = 3'b001; commit_free_valid = 3'b001;
                    commit_free_tag = {6'd0, 6'd0, 6'd44}; sq_valid = 3'b011;
                    sb.push_back(ex(3'b000, 3'b000, 3'b000, '0, 3'b000, '0, 1'b0, 1'b1, 5'd2));
                end
                default: begin
                    reset = 1'b0; disp_valid = 3'b001; disp_has_dest = 3'b001;
                    fl_free_valid = 3'b001; fl_free_reg = {6'd0, 6'd0, 6'd3};
                    sb.push_back(ex(3'b001, 3'b001, 3'b001, {6'd0, 6'd0, 6'd3}, 3'b000, '0, 1'b0, 1'b0, 5'd0));
                end
            endcase
            #2;
            e = sb.pop_front();
            n_tests++; if (disp_grant !== e.grant) begin n_fail++; $display("FAIL midreset[%0d] grant got %b want %b", t, disp_grant, e.grant); end
            n_tests++; if (fl_dispatch_en !== e.den) begin n_fail++; $display("FAIL midreset[%0d] dispatch_en got %b want %b", t, fl_dispatch_en, e.den); end
            for (int i = 0; i < 3; i++) if (e.tmask[i]) begin
                n_tests++; if (disp_tag[i] !== e.tag[i]) begin n_fail++; $display("FAIL midreset[%0d] tag%0d got %0d want %0d", t, i, disp_tag[i], e.tag[i]); end
            end
            n_tests++; if (fl_retire_en !== e.ren) begin n_fail++; $display("FAIL midreset[%0d] retire_en got %b want %b", t, fl_retire_en, e.ren); end
            n_tests++; if (fl_retire_reg !== e.rreg) begin n_fail++; $display("FAIL midreset[%0d] retire_reg got %h want %h", t, fl_retire_reg, e.rreg); end
            n_tests++; if (sq_ready !== e.rdy) begin n_fail++; $display("FAIL midreset[%0d] sq_ready got %b want %b", t, sq_ready, e.rdy); end
            n_tests++; if (recovering !== e.rec) begin n_fail++; $display("FAIL midreset[%0d] recovering got %b want %b", t, recovering, e.rec); end
            n_tests++; if (sq_freed !== e.freed) begin n_fail++; $display("FAIL midreset[%0d] sq_freed got %0d want %0d", t, sq_freed, e.freed); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        test_reset();
        test_dispatch();
        test_squash_walk();
        test_squash_zero();
        test_reset_mid_recover();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
